// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffers: default widths,
// control-word field offsets, MemtoReg encodings and the payload layout.
package pipe_pkg;

    localparam int DW_DEF    = 32;
    localparam int NCH_DEF   = 3;
    localparam int CTRLW_DEF = 10;
    localparam int PC_W      = 32;

    localparam int REGWRITE_BIT = 0;
    localparam int MEMTOREG_LSB = 1;
    localparam int MEMTOREG_W   = 4;
    localparam int DST_LSB      = 5;
    localparam int DST_W        = 5;

    typedef enum logic [MEMTOREG_W-1:0] {
        MTR_ALU = 4'd0,
        MTR_MEM = 4'd1,
        MTR_PC8 = 4'd2,
        MTR_IMM = 4'd3
    } memtoreg_e;

    // Payload for the default configuration; the stage packs in this order.
    typedef struct packed {
        logic [PC_W-1:0]           pc;
        logic [CTRLW_DEF-1:0]      ctrl;
        logic [NCH_DEF*DW_DEF-1:0] data;
    } payload_t;

endpackage

// File: rtl/pipe_slot.sv
// One payload register plus its valid bit. Clear dominates load.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    logic         valid_d, valid_q;
    logic [W-1:0] data_d, data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign q     = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, flush and optional skid entry.
// Define PIPE_PERF_EN to build the stall/transfer performance counters.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int NCH   = NCH_DEF,
    parameter int CTRLW = CTRLW_DEF,
    parameter int SKID  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [CTRLW-1:0]  in_ctrl,
    input  logic [NCH*DW-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [CTRLW-1:0]  out_ctrl,
    output logic [NCH*DW-1:0] out_data,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_xfer_cnt
);

    localparam int PW = 32 + CTRLW + NCH*DW;

    logic [PW-1:0] in_pl, main_src, main_pl, skid_pl;
    logic          accept, xfer;
    logic          main_v, skid_v;
    logic          main_load, main_clr, skid_load, skid_clr;

    assign in_pl    = {in_pc, in_ctrl, in_data};
    assign in_ready = (SKID != 0) ? !skid_v : (!main_v || out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign xfer     = main_v && out_ready;
    // Skid is only ever non-empty behind a full main entry, so it wins the refill.
    assign main_src = skid_v ? skid_pl : in_pl;

    always_comb begin
        main_load = 1'b0;
        main_clr  = flush;
        skid_load = 1'b0;
        skid_clr  = flush;
        if (SKID != 0) begin
            if (!main_v) begin
                main_load = accept;
            end else if (xfer) begin
                main_load = skid_v || accept;
                main_clr  = flush || (!skid_v && !accept);
                skid_clr  = flush || skid_v;
            end else begin
                skid_load = accept;
            end
        end else begin
            main_load = accept;
            main_clr  = flush || (xfer && !accept);
        end
    end

    pipe_slot #(.W(PW)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .clr   (main_clr),
        .d     (main_src),
        .valid (main_v),
        .q     (main_pl)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(.W(PW)) u_skid (
                .clk   (clk),
                .reset (reset),
                .load  (skid_load),
                .clr   (skid_clr),
                .d     (in_pl),
                .valid (skid_v),
                .q     (skid_pl)
            );
        end else begin : g_noskid
            assign skid_v  = 1'b0;
            assign skid_pl = '0;
        end
    endgenerate

    assign out_valid = main_v;
    assign out_pc    = main_pl[PW-1 -: 32];
    assign out_ctrl  = main_v ? main_pl[NCH*DW +: CTRLW] : '0;
    assign out_data  = main_pl[NCH*DW-1:0];

`ifdef PIPE_PERF_EN
    logic [31:0] stall_cnt_d, stall_cnt_q, xfer_cnt_d, xfer_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        xfer_cnt_d  = xfer_cnt_q;
        if (main_v && !out_ready && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (xfer && xfer_cnt_q != 32'hFFFF_FFFF)
            xfer_cnt_d = xfer_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_xfer_cnt  = xfer_cnt_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_xfer_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: one SKID=1 and one SKID=0 instance.
module tb_pipe_stage_buf;

    localparam int DW = 32, NCH = 3, CTRLW = 10;

    logic clk = 1'b0, reset = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // SKID=1 instance signals
    logic              f1 = 0, v1 = 0, r1 = 0, ir1, ov1;
    logic [31:0]       pc1 = 0, opc1, st1, xf1;
    logic [CTRLW-1:0]  oc1;
    logic [NCH*DW-1:0] od1;
    // SKID=0 instance signals
    logic              f0 = 0, v0 = 0, r0 = 0, ir0, ov0;
    logic [31:0]       pc0 = 0, opc0, st0, xf0;
    logic [CTRLW-1:0]  oc0;
    logic [NCH*DW-1:0] od0;

    logic [31:0] q1[$], q0[$];

    function automatic logic [CTRLW-1:0] mk_ctrl(input logic [31:0] pc);
        return pc[11:2] ^ 10'h155;
    endfunction

    function automatic logic [NCH*DW-1:0] mk_data(input logic [31:0] pc);
        return {pc ^ 32'hA5A5_0000, pc + 32'd8, ~pc};
    endfunction

    pipe_stage_buf #(.DW(DW), .NCH(NCH), .CTRLW(CTRLW), .SKID(1)) dut1 (
        .clk(clk), .reset(reset), .flush(f1), .in_valid(v1), .in_ready(ir1),
        .in_pc(pc1), .in_ctrl(mk_ctrl(pc1)), .in_data(mk_data(pc1)),
        .out_valid(ov1), .out_ready(r1), .out_pc(opc1), .out_ctrl(oc1), .out_data(od1),
        .perf_stall_cnt(st1), .perf_xfer_cnt(xf1)
    );

    pipe_stage_buf #(.DW(DW), .NCH(NCH), .CTRLW(CTRLW), .SKID(0)) dut0 (
        .clk(clk), .reset(reset), .flush(f0), .in_valid(v0), .in_ready(ir0),
        .in_pc(pc0), .in_ctrl(mk_ctrl(pc0)), .in_data(mk_data(pc0)),
        .out_valid(ov0), .out_ready(r0), .out_pc(opc0), .out_ctrl(oc0), .out_data(od0),
        .perf_stall_cnt(st0), .perf_xfer_cnt(xf0)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: pop one expected PC per handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (ov1 && r1) begin
                if (q1.size() == 0) chk("sb1_unexpected_pc", opc1, 32'hDEAD_BEEF);
                else begin
                    logic [31:0] e;
                    e = q1.pop_front();
                    chk("sb1_pc", opc1, e);
                    chk("sb1_ctrl", oc1, mk_ctrl(e));
                    chk("sb1_data", od1, mk_data(e));
                end
            end else if (!ov1) chk("sb1_bubble_ctrl", oc1, 0);
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (ov0 && r0) begin
                if (q0.size() == 0) chk("sb0_unexpected_pc", opc0, 32'hDEAD_BEEF);
                else begin
                    logic [31:0] e;
                    e = q0.pop_front();
                    chk("sb0_pc", opc0, e);
                    chk("sb0_ctrl", oc0, mk_ctrl(e));
                    chk("sb0_data", od0, mk_data(e));
                end
            end else if (!ov0) chk("sb0_bubble_ctrl", oc0, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with inputs active
        v1 = 1; pc1 = 32'h1234; v0 = 1; pc0 = 32'h5678; r1 = 1; r0 = 1;
        repeat (3) step();
        chk("rst_ov1", ov1, 0);  chk("rst_oc1", oc1, 0);  chk("rst_opc1", opc1, 0);
        chk("rst_ov0", ov0, 0);  chk("rst_oc0", oc0, 0);  chk("rst_opc0", opc0, 0);
        v1 = 0; v0 = 0; r1 = 0; r0 = 0;
        reset = 1;
        step();
        chk("rst_ir1", ir1, 1);  chk("rst_ir0", ir0, 1);
        chk("rst_ov1_after", ov1, 0);

        // Perf: 5 stall cycles then 3 transfers on the skid instance
        v1 = 1; pc1 = 32'h100; q1.push_back(pc1);
        step();
        v1 = 0;
        repeat (5) step();
        chk("bp_hold_pc", opc1, 32'h100);
        r1 = 1; v1 = 1; pc1 = 32'h104; q1.push_back(pc1);
        step();
        pc1 = 32'h108; q1.push_back(pc1);
        step();
        v1 = 0;
        step();
`ifdef PIPE_PERF_EN
        chk("perf_stall", st1, 5);
        chk("perf_xfer", xf1, 3);
`else
        chk("perf_stall_off", st1, 0);
        chk("perf_xfer_off", xf1, 0);
`endif
        chk("perf_idle_stall0", st0, 0);
        chk("perf_idle_xfer0", xf0, 0);

        // Streaming, SKID=1, no gaps
        v1 = 1; pc1 = 32'h3000; q1.push_back(pc1);
        step();
        chk("st_ov_a", ov1, 1); chk("st_ir_a", ir1, 1);
        pc1 = 32'h3004; q1.push_back(pc1);
        step();
        chk("st_ov_b", ov1, 1); chk("st_ir_b", ir1, 1);
        pc1 = 32'h3008; q1.push_back(pc1);
        step();
        chk("st_ov_c", ov1, 1); chk("st_pc_c", opc1, 32'h3008);
        v1 = 0;
        step();
        chk("st_drained", ov1, 0);

        // Back-pressure, SKID=1
        r1 = 0; v1 = 1; pc1 = 32'h3000; q1.push_back(pc1);
        step();
        chk("bp_ir_one", ir1, 1);
        pc1 = 32'h3004; q1.push_back(pc1);
        step();
        v1 = 0;
        chk("bp_ir_full", ir1, 0);
        repeat (3) step();
        chk("bp_stable_pc", opc1, 32'h3000);
        chk("bp_stable_ov", ov1, 1);
        chk("bp_ir_held", ir1, 0);
        r1 = 1;
        step();
        chk("bp_ir_back", ir1, 1);
        chk("bp_second_pc", opc1, 32'h3004);
        step();
        chk("bp_drained", ov1, 0);

        // Flush with main+skid full and a new input offered
        r1 = 0; v1 = 1; pc1 = 32'h4000;
        step();
        pc1 = 32'h4004;
        step();
        chk("fl_full_ir", ir1, 0);
        f1 = 1; pc1 = 32'h4008;
        step();
        f1 = 0; v1 = 0;
        chk("fl_ov", ov1, 0); chk("fl_oc", oc1, 0); chk("fl_ir", ir1, 1);
        r1 = 1;
        repeat (3) step();
        chk("fl_nothing", ov1, 0);

        // SKID=0: combinational in_ready and pass-through replace
        r0 = 0; v0 = 1; pc0 = 32'h5000; q0.push_back(pc0);
        step();
        pc0 = 32'h5004;
        #1 chk("s0_ir_blocked", ir0, 0);
        r0 = 1;
        #1 chk("s0_ir_comb", ir0, 1);
        q0.push_back(pc0);
        step();
        chk("s0_replace_pc", opc0, 32'h5004);
        pc0 = 32'h5008; q0.push_back(pc0);
        step();
        chk("s0_replace_pc2", opc0, 32'h5008);
        v0 = 0;
        step();
        chk("s0_drained", ov0, 0);

        // SKID=0 flush overrides an accept into an empty stage
        v0 = 1; f0 = 1; pc0 = 32'h6000;
        step();
        v0 = 0; f0 = 0;
        chk("s0_fl_ov", ov0, 0); chk("s0_fl_ir", ir0, 1);
        repeat (2) step();

        chk("sb1_leftover", q1.size(), 0);
        chk("sb0_leftover", q0.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
